// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between the requesters and rr_hold_arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface rr_hold_arbiter_if #(
   parameter int NUM_PORTS = 5
);
   localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NUM_PORTS-1:0] req_i;
   logic [NUM_PORTS-1:0] gnt_o;
   logic [ID_W-1:0]      gnt_id_o;
   logic                 busy_o;
   logic                 timeout_o;

   modport master (
      output req_i,
      input  gnt_o, gnt_id_o, busy_o, timeout_o
   );

   modport slave (
      input  req_i,
      output gnt_o, gnt_id_o, busy_o, timeout_o
   );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter: an owner keeps the grant until it drops its
// request or has held it for MAX_HOLD cycles (0 = unlimited).
module rr_hold_arbiter #(
   parameter int NUM_PORTS = 5,
   parameter int MAX_HOLD  = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   rr_hold_arbiter_if.slave bus
);
   localparam int ID_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int HCNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t               r_state, w_state_nxt;
   logic [ID_W-1:0]      r_owner, w_owner_nxt;
   logic [ID_W-1:0]      r_ptr, w_ptr_nxt;
   logic [HCNT_W-1:0]    r_hcnt, w_hcnt_nxt;
   logic [NUM_PORTS-1:0] r_gnt, w_gnt_nxt;
   logic                 r_busy, w_busy_nxt;
   logic                 r_timeout, w_timeout_nxt;

   logic                 w_req_own;
   logic                 w_release;
   logic                 w_tmo_edge;
   logic [NUM_PORTS-1:0] w_mask;
   logic [NUM_PORTS-1:0] w_req_m;
   logic                 w_win_vld;
   logic [ID_W-1:0]      w_win;
   logic [ID_W-1:0]      w_win_inc;

   assign w_req_own  = bus.req_i[r_owner];
   assign w_release  = (r_state == GRANT) && !w_req_own;
   // Release wins over timeout, so timeout requires the owner still requesting.
   assign w_tmo_edge = (MAX_HOLD != 0) && (r_state == GRANT) && w_req_own &&
                       (r_hcnt == HCNT_W'(MAX_HOLD));

   always_comb begin
      w_mask = '1;
      if (w_tmo_edge) w_mask[r_owner] = 1'b0;
   end

   assign w_req_m = bus.req_i & w_mask;

   // First set bit in rotation order starting at r_ptr.
   always_comb begin
      int idx;
      w_win_vld = 1'b0;
      w_win     = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = int'(r_ptr) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!w_win_vld && w_req_m[idx]) begin
            w_win_vld = 1'b1;
            w_win     = ID_W'(idx);
         end
      end
   end

   assign w_win_inc = (w_win == ID_W'(NUM_PORTS - 1)) ? '0 : w_win + ID_W'(1);

   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_ptr_nxt     = r_ptr;
      w_hcnt_nxt    = r_hcnt;
      w_gnt_nxt     = r_gnt;
      w_busy_nxt    = r_busy;
      w_timeout_nxt = 1'b0;
      if ((r_state == IDLE) || w_release || w_tmo_edge) begin
         w_timeout_nxt = w_tmo_edge;
         if (w_win_vld) begin
            w_state_nxt        = GRANT;
            w_owner_nxt        = w_win;
            w_ptr_nxt          = w_win_inc;
            w_hcnt_nxt         = HCNT_W'(1);
            w_gnt_nxt          = '0;
            w_gnt_nxt[w_win]   = 1'b1;
            w_busy_nxt         = 1'b1;
         end else begin
            w_state_nxt = IDLE;
            w_owner_nxt = '0;
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
         end
      end else begin
         w_hcnt_nxt = r_hcnt + HCNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_owner   <= '0;
         r_ptr     <= '0;
         r_hcnt    <= '0;
         r_gnt     <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_owner   <= w_owner_nxt;
         r_ptr     <= w_ptr_nxt;
         r_hcnt    <= w_hcnt_nxt;
         r_gnt     <= w_gnt_nxt;
         r_busy    <= w_busy_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign bus.gnt_o     = r_gnt;
   assign bus.gnt_id_o  = r_owner;
   assign bus.busy_o    = r_busy;
   assign bus.timeout_o = r_timeout;
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Randomized and directed check of rr_hold_arbiter against a tenure-level model.
module tb_rr_hold_arbiter;
   localparam int N  = 5;
   localparam int MH = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   rr_hold_arbiter_if #(.NUM_PORTS(N)) bus ();

   rr_hold_arbiter #(.NUM_PORTS(N), .MAX_HOLD(MH)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   // Model: who owns the resource, how long it has held, where rotation resumes.
   int m_own = -1;
   int m_ten = 0;
   int m_ptr = 0;
   bit m_to  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
      for (int i = 0; i < N; i++) begin
         int p = (start + i) % N;
         if (r[p] && p != excl) return p;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_own = -1; m_ten = 0; m_ptr = 0; m_to = 0;
   endtask

   task automatic model_take(input int w);
      if (w >= 0) begin
         m_own = w; m_ten = 1; m_ptr = (w + 1) % N;
      end else begin
         m_own = -1;
      end
   endtask

   task automatic model_edge(input logic [N-1:0] r);
      m_to = 0;
      if (m_own < 0)            model_take(pick(r, m_ptr, -1));
      else if (!r[m_own])       model_take(pick(r, m_ptr, -1));
      else if (m_ten == MH) begin
         m_to = 1;
         model_take(pick(r, m_ptr, m_own));
      end else                  m_ten++;
   endtask

   task automatic check_outputs(input string tag);
      logic [N-1:0] eg;
      eg = (m_own < 0) ? '0 : N'(1) << m_own;
      chk({tag, ".gnt"},  32'(bus.gnt_o),     32'(eg));
      chk({tag, ".id"},   32'(bus.gnt_id_o),  32'((m_own < 0) ? 0 : m_own));
      chk({tag, ".busy"}, 32'(bus.busy_o),    32'(m_own >= 0));
      chk({tag, ".tmo"},  32'(bus.timeout_o), 32'(m_to));
      chk({tag, ".oh0"},  32'($onehot0(bus.gnt_o)), 32'(1));
   endtask

   task automatic step(input logic [N-1:0] r, input string tag);
      bus.req_i = r;
      @(posedge clk_i);
      if (!rst_i) model_edge(r);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      bus.req_i = '1;
      #1;
      model_reset();
      check_outputs("rst_async");
      step('1, "rst_hold");
      step('1, "rst_hold");
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      logic [N-1:0] r;
      bus.req_i = '1;
      #1;
      check_outputs("por");
      step('1, "rst_hold");
      @(negedge clk_i);
      rst_i = 1'b0;

      // Rotation with everybody requesting.
      step('1, "rot");
      chk("rot_first", 32'(bus.gnt_o), 32'h01);
      for (int i = 0; i < 3; i++) step('1, "rot");
      step('1, "rot");
      chk("rot_hand_gnt", 32'(bus.gnt_o), 32'h02);
      chk("rot_hand_tmo", 32'(bus.timeout_o), 32'h1);
      for (int i = 0; i < 22; i++) step('1, "rot");

      // Async reset mid-tenure.
      #2;
      rst_i = 1'b1;
      #1;
      model_reset();
      chk("rst_mid_gnt", 32'(bus.gnt_o), 32'h0);
      check_outputs("rst_mid");
      @(negedge clk_i);
      rst_i = 1'b0;

      // Release handover.
      do_reset();
      step(5'b00101, "rel");
      chk("rel_first", 32'(bus.gnt_o), 32'h01);
      step(5'b00101, "rel");
      step(5'b00100, "rel");
      chk("rel_gnt", 32'(bus.gnt_o), 32'h04);
      chk("rel_id",  32'(bus.gnt_id_o), 32'h2);
      chk("rel_tmo", 32'(bus.timeout_o), 32'h0);

      // Sole requester timeout.
      do_reset();
      for (int i = 0; i < 4; i++) step(5'b01000, "sole");
      chk("sole_held", 32'(bus.gnt_o), 32'h08);
      step(5'b01000, "sole");
      chk("sole_gap_gnt", 32'(bus.gnt_o), 32'h00);
      chk("sole_gap_tmo", 32'(bus.timeout_o), 32'h1);
      step(5'b01000, "sole");
      chk("sole_regrant", 32'(bus.gnt_o), 32'h08);

      // No preemption; pointer wraps after port 3.
      do_reset();
      step(5'b01000, "npre");
      step(5'b01000, "npre");
      step(5'b01001, "npre");
      chk("npre_hold", 32'(bus.gnt_o), 32'h08);
      step(5'b00001, "npre");
      chk("npre_wrap", 32'(bus.gnt_o), 32'h01);

      // Release on the timeout edge.
      do_reset();
      for (int i = 0; i < 4; i++) step(5'b00001, "coll");
      step(5'b00000, "coll");
      chk("coll_gnt",  32'(bus.gnt_o), 32'h0);
      chk("coll_busy", 32'(bus.busy_o), 32'h0);
      chk("coll_tmo",  32'(bus.timeout_o), 32'h0);

      // Random level requests with occasional toggles and rare resets.
      do_reset();
      r = N'($urandom);
      for (int i = 0; i < 2000; i++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
         if ($urandom_range(0, 499) == 0) do_reset();
         step(r, "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Registered round-robin arbiter with grant hold and bounded tenure. It shares one resource (bus, memory port, results converter) among NUM_PORTS requesters. A granted requester keeps the resource until it drops its request or hits a hold limit. Rotating priority guarantees starvation freedom, replacing fixed-priority selection where fairness is needed.

## Interface
- NUM_PORTS, default 5: number of requesters; must be ≥ 2.
- MAX_HOLD, default 16: maximum consecutive grant cycles per tenure; 0 means unlimited, no timeout.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- req_i  input  NUM_PORTS  request vector; bit k = requester k wants the resource; level-sensitive.
- gnt_o  output  NUM_PORTS  registered grant; onehot0 at all times.
- gnt_id_o  output  max(1,$clog2(NUM_PORTS))  index of current owner; 0 when gnt_o == 0.
- busy_o  output  1  high while any grant is held (equals |gnt_o).
- timeout_o  output  1  one-cycle pulse in the first cycle after a tenure is revoked by MAX_HOLD.

## Operation
- State: FSM {IDLE, GRANT}, owner index, round-robin pointer ptr (0..NUM_PORTS-1), hold counter hcnt of width $clog2(MAX_HOLD+1).
- Arbitration (combinational, on req_i & mask):
  - Search order: ptr, ptr+1, …, NUM_PORTS-1, 0, …, ptr-1.
  - The first set bit wins.
  - mask excludes the current owner only on a timeout edge; otherwise mask is all ones.
- IDLE:
  - If any req_i bit is set, the winner is granted at the next edge.
  - On that edge: state GRANT, hcnt=1, ptr = winner+1, wrapping NUM_PORTS-1 → 0.
- GRANT, evaluated at each edge:
  - **Release:** req_i[owner]==0. Revoke the grant. In the same edge, arbitrate the remaining requests. If a winner exists, grant it with no gap (hcnt=1, ptr updated). Otherwise go to IDLE and set gnt_o=0.
  - **Timeout:** MAX_HOLD≠0, hcnt==MAX_HOLD, and req_i[owner]==1. Revoke the grant and set timeout_o=1 for the next cycle. Arbitrate with the owner masked. If no other requester exists, go to IDLE with gnt_o=0 for one cycle; the owner may win again at the following edge.
  - **Hold:** in all other cases gnt_o is unchanged, hcnt increments, and new requests are ignored. There is no preemption.
- Release takes precedence over timeout when both apply on the same edge; timeout_o stays 0.
- Requests on non-owner bits are never lost: they stay level and are served in rotation order.
- gnt_id_o and busy_o are registered alongside gnt_o and are always consistent with it.
- Reset (async assert, any state):
  - Outputs: gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0.
  - Internal: ptr=0, hcnt=0, state IDLE.
  - While rst_i is high, req_i is ignored. The first grant can occur at the first rising edge after rst_i falls.

## Timing
- Grant latency: request seen at edge k → gnt_o valid from edge k (visible in cycle k+1); 1 cycle from an idle request.
- Handover latency on release: 0 idle cycles between consecutive owners.
- Handover after timeout: 0 idle cycles if another requester is present; 1 idle cycle if the owner is the sole requester.
- Maximum tenure: MAX_HOLD cycles of gnt_o high.
- Worst-case wait for a continuously requesting port: (NUM_PORTS-1)·MAX_HOLD cycles when MAX_HOLD≠0.
- timeout_o is high exactly one cycle, aligned with the cycle in which the new gnt_o (or zero) first appears.
- Reset deassertion is synchronous to clk_i and is the integrator's responsibility.

## Test plan
- **Reset:** rst_i=1 with req_i=11111 → gnt_o=00000, busy_o=0, timeout_o=0. After rst_i=0, the first edge gives gnt_o=00001, gnt_id_o=0. Assert rst_i mid-tenure → gnt_o=00000 immediately, without waiting for a clock edge.
- **Rotation (MAX_HOLD=4, req_i=11111 constant):**
  - Each port holds for 4 cycles: 00001 → 00010 → 00100 → 01000 → 10000 → 00001.
  - timeout_o pulses at each handover.
  - No idle gaps occur, and gnt_o is onehot at every cycle.
- **Release handover:** req_i=00101 from idle → gnt_o=00001. Drop req_i[0] after 2 cycles → the next edge gives gnt_o=00100, gnt_id_o=2, timeout_o=0, with no gap.
- **Sole-requester timeout (MAX_HOLD=4):** req_i=01000 constant → gnt_o=01000 for 4 cycles, then one cycle of gnt_o=00000 with timeout_o=1, then gnt_o=01000 again.
- **No preemption:** port 3 owns the grant; raise req_i[0] → gnt_o stays 01000 until port 3 releases. Then gnt_o=00001 (ptr=4 wraps to 0).
- **Release/timeout collision:** owner drops req on the edge where hcnt==MAX_HOLD → release is taken, timeout_o=0. With req_i=00000, gnt_o=00000 and busy_o=0 on the next cycle.
